// File: rtl/hog_pkg.sv
// rtl/hog_pkg.sv - shared HOG histogram geometry constants
package hog_pkg;

  // Width of one orientation or magnitude-sum bin
  localparam int BIN_WIDTH       = 11;
  // Orientation bins 0..BINS-2 plus one trailing magnitude-sum bin
  localparam int BINS            = 10;
  // Wide enough to count 0..BINS-1
  localparam int INDEX_WIDTH     = 4;
  // Position of the magnitude-sum bin, always the last one
  localparam int SUM_BIN         = BINS - 1;
  localparam int HISTOGRAM_WIDTH = BIN_WIDTH * BINS;

endpackage

// File: rtl/hist_pingpong_buffer.sv
// rtl/hist_pingpong_buffer.sv - two-slot histogram buffer with occupancy count
module hist_pingpong_buffer #(
  parameter int WIDTH = hog_pkg::HISTOGRAM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  // pop is only asserted while out_valid is high
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] slot [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;

  // Readiness comes from registered state only, so a completing pop never
  // frees a slot within the same cycle
  assign in_ready  = rst && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign head      = slot[rd_ptr];

  // Slot write, pointer toggling and occupancy tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= in_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/histogram_serializer.sv
// rtl/histogram_serializer.sv - packed histogram to bin-serial beat stream
module histogram_serializer #(
  parameter int BIN_WIDTH       = hog_pkg::BIN_WIDTH,
  parameter int BINS            = hog_pkg::BINS,
  parameter int HISTOGRAM_WIDTH = BIN_WIDTH * BINS,
  parameter int INDEX_WIDTH     = hog_pkg::INDEX_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [HISTOGRAM_WIDTH-1:0] row_histogram,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INDEX_WIDTH-1:0]     bin_index,
  output logic [BIN_WIDTH-1:0]       bin_value,
  output logic                       out_last
);

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(BINS - 1);

  logic [HISTOGRAM_WIDTH-1:0] head;
  logic [INDEX_WIDTH-1:0]     bin_cnt;
  logic                       xfer;
  logic                       pop;

  hist_pingpong_buffer #(
    .WIDTH (HISTOGRAM_WIDTH)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (row_histogram),
    .pop       (pop),
    .out_valid (out_valid),
    .head      (head)
  );

  assign xfer      = out_valid && out_ready;
  assign out_last  = out_valid && (bin_cnt == LAST_INDEX);
  // Retire the head slot on the beat carrying the magnitude sum
  assign pop       = xfer && out_last;
  assign bin_index = bin_cnt;

  // Select the current bin of the head histogram
  always_comb begin
    bin_value = '0;
    for (int k = 0; k < BINS; k++) begin
      if (bin_cnt == INDEX_WIDTH'(k)) begin
        bin_value = head[k*BIN_WIDTH +: BIN_WIDTH];
      end
    end
  end

  // Bin counter advances per accepted beat and wraps after the sum bin
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_cnt <= '0;
    end else if (xfer) begin
      bin_cnt <= out_last ? '0 : bin_cnt + INDEX_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_histogram_serializer.sv
// tb/tb_histogram_serializer.sv - self-checking bench for histogram_serializer
module tb_histogram_serializer;

  localparam int BW = hog_pkg::BIN_WIDTH;
  localparam int NB = hog_pkg::BINS;
  localparam int IW = hog_pkg::INDEX_WIDTH;
  localparam int HW = BW * NB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [HW-1:0] row_histogram = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] bin_index;
  logic [BW-1:0] bin_value;
  logic          out_last;

  histogram_serializer dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .row_histogram (row_histogram),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .bin_index     (bin_index),
    .bin_value     (bin_value),
    .out_last      (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int val;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    beats = 0;
  int    accepts = 0;
  bit    acc_flag = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [HW-1:0] rand_word();
    logic [HW-1:0] w;
    for (int k = 0; k < NB; k++) w[k*BW +: BW] = BW'($urandom);
    return w;
  endfunction

  // Expected stream for one histogram: every bin in order, sum bin last
  task automatic push_hist(input logic [HW-1:0] w);
    beat_t b;
    for (int k = 0; k < NB; k++) begin
      b.idx  = k;
      b.val  = int'(w[k*BW +: BW]);
      b.last = (k == NB - 1);
      exp_q.push_back(b);
    end
  endtask

  // Check outputs against the model, then advance one clock
  task automatic step();
    int held;
    bit xfer;
    held = (exp_q.size() + NB - 1) / NB;
    chk("in_ready", in_ready, 32'(rst && held < 2));
    chk("out_valid", out_valid, 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("bin_index", bin_index, exp_q[0].idx);
      chk("bin_value", bin_value, exp_q[0].val);
      chk("out_last", out_last, 32'(exp_q[0].last));
    end else begin
      chk("out_last_idle", out_last, 0);
    end
    acc_flag = in_valid && rst && (held < 2);
    xfer     = out_ready && (exp_q.size() != 0);
    if (xfer) begin
      beats++;
      void'(exp_q.pop_front());
    end
    if (acc_flag) begin
      accepts++;
      push_hist(row_histogram);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size() == 0), 1);
  endtask

  initial begin
    int b0;
    int a0;
    int cycles;
    int n_acc;
    int third_cycle;
    int n;
    logic [HW-1:0] w;

    // Reset held low for five cycles
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_bin_index", bin_index, 0);
      chk("rst_bin_value", bin_value, 0);
    end
    rst = 1'b1;
    #1;
    chk("in_ready_after_release", in_ready, 1);

    // Single histogram: bins 1..9, sum 45
    for (int k = 0; k < NB - 1; k++) w[k*BW +: BW] = BW'(k + 1);
    w[(NB-1)*BW +: BW] = BW'(45);
    row_histogram = w;
    in_valid = 1'b1;
    out_ready = 1'b1;
    b0 = beats;
    step();
    in_valid = 1'b0;
    drain(40);
    chk("single_beats", beats - b0, NB);
    chk("single_idle", out_valid, 0);

    // Back-to-back: three histograms offered continuously
    b0 = beats;
    cycles = 0;
    n_acc = 0;
    third_cycle = 0;
    row_histogram = rand_word();
    in_valid = 1'b1;
    while ((n_acc < 3 || exp_q.size() != 0) && cycles < 200) begin
      step();
      cycles++;
      if (acc_flag) begin
        n_acc++;
        if (n_acc == 3) third_cycle = cycles;
        if (n_acc < 3) row_histogram = rand_word();
        else in_valid = 1'b0;
      end
    end
    chk("b2b_beats", beats - b0, 3 * NB);
    chk("b2b_cycles", cycles, 3 * NB + 1);
    chk("b2b_third_accept", third_cycle, NB + 2);

    // Backpressure: all bins at full scale, ready pattern 1,0,0,...
    for (int k = 0; k < NB; k++) w[k*BW +: BW] = '1;
    row_histogram = w;
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    b0 = beats;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      out_ready = (n % 3 == 0);
      step();
      n++;
    end
    chk("bp_drained", 32'(exp_q.size() == 0), 1);
    chk("bp_beats", beats - b0, NB);

    // Randomized traffic on both sides
    b0 = beats;
    a0 = accepts;
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = ($urandom % 4) != 0;
      row_histogram = rand_word();
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(100);
    chk("rand_beats_per_hist", beats - b0, (accepts - a0) * NB);

    // Reset mid-stream after beat 4
    row_histogram = rand_word();
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    b0 = beats;
    n = 0;
    while (beats - b0 < 5 && n < 50) begin
      step();
      n++;
    end
    chk("mid_beats_before_reset", beats - b0, 5);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_bin_index", bin_index, 0);
    chk("mid_rst_bin_value", bin_value, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    row_histogram = rand_word();
    in_valid = 1'b1;
    b0 = beats;
    step();
    in_valid = 1'b0;
    drain(40);
    chk("post_reset_beats", beats - b0, NB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/histogram_serializer.md
# histogram_serializer

Unpacks the packed per-row histogram word (BINS bins of BIN_WIDTH bits each; the last bin holds the magnitude sum) into a stream of one (bin_index, bin_value) beat per cycle. It sits directly downstream of row_histogram and feeds bin-serial consumers such as cell accumulation and normalisation. A two-entry buffer lets the next histogram be accepted while the current one is still being emitted.

## Interface
Parameters:
- BIN_WIDTH, 11, width of one bin
- BINS, 10, bins per histogram; bins 0..BINS-2 are orientation bins, BINS-1 is the magnitude sum; legal range 2..16
- HISTOGRAM_WIDTH, BIN_WIDTH*BINS, packed input width
- INDEX_WIDTH, 4, width of bin_index; must satisfy 2^INDEX_WIDTH >= BINS

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  row_histogram is valid
- in_ready  out  1  block can accept a histogram
- row_histogram  in  HISTOGRAM_WIDTH  bin k is at [k*BIN_WIDTH +: BIN_WIDTH]
- out_valid  out  1  current beat is valid
- out_ready  in  1  downstream accepts the beat
- bin_index  out  INDEX_WIDTH  index of the current bin, 0..BINS-1
- bin_value  out  BIN_WIDTH  value of the current bin
- out_last  out  1  high on the beat with bin_index == BINS-1

## Operation
- Input transfer: in_valid && in_ready at a rising edge. The whole word is captured into the buffer slot at the write pointer.
- Output transfer: out_valid && out_ready at a rising edge.
- Buffer:
  - Two slots, with write pointer, read pointer and an occupancy count of 0..2.
  - in_ready = (rst high) && (count != 2). It depends only on registered state, never on out_ready or in_valid.
- Emission:
  - out_valid = (count != 0).
  - bin_index = bin counter.
  - bin_value = head slot, bin[bin_counter].
  - out_last = out_valid && (bin_counter == BINS-1).
  - Bins are emitted in ascending order 0..BINS-1. The bin counter increments on each output transfer.
  - On the transfer with out_last high: the bin counter resets to 0, the read pointer toggles and the count decrements.
- Simultaneous input and final-beat transfer with count == 1: count stays 1, and the new slot becomes head on the next cycle with no bubble.
- With count == 2, in_ready is low even if the final beat is transferring that cycle. in_ready rises on the following cycle.
- Stall: while out_valid && !out_ready, bin_index, bin_value and out_last hold their values. Buffer contents never change except by an input transfer into a free slot.
- Values pass through unmodified. There is no arithmetic, saturation or reordering.
- Reset (rst low, asynchronous):
  - count = 0, both pointers = 0, bin counter = 0.
  - out_valid = 0, out_last = 0, in_ready = 0, bin_index = 0, bin_value = 0. Slot contents are cleared to 0.
  - Assertion mid-stream drops out_valid immediately and discards any partially emitted histogram.

## Timing
- Latency: a histogram accepted at edge N has its bin 0 on the outputs with out_valid high after edge N.
- Throughput: BINS beats per histogram with no gaps between histograms while out_ready stays high and the input keeps the buffer non-empty.
- After reset release, in_ready goes high in the first cycle.
- Stall cycles do not change the beat order or count. Every accepted histogram yields exactly BINS beats.

## Structure
- Shared package hog_pkg holds BIN_WIDTH, BINS, INDEX_WIDTH and the sum-bin index constant (BINS-1). row_histogram and this block both import it.
- Sub-module hist_pingpong_buffer contains the two slots, the pointers, the count and in_ready/out_valid generation.
- The top level holds the bin counter, the output mux and out_last.

## Test plan
- Reset: hold rst low for 5 cycles.
  - While low: out_valid = 0, in_ready = 0, bin_index = 0, bin_value = 0.
  - In the first cycle after release: in_ready = 1.
- Single histogram, out_ready = 1: bins 0..8 = 1..9 and bin 9 = 45.
  - Expect 10 consecutive beats: index 0..9, values 1,2,...,9,45.
  - out_last is high only on index 9, and out_valid drops on the next cycle.
- Back-to-back: three histograms offered continuously, out_ready = 1.
  - Expect 30 contiguous beats with no bubble.
  - in_ready goes low after two accepts and rises one cycle after the first out_last transfer.
- Backpressure: all bins = 2047, out_ready following pattern 1,0,0,1,0,...
  - Outputs hold while stalled.
  - Exactly 10 beats, each 2047, with no index skipped or repeated.
- Full plus completion: count = 2, in_valid held, and the final beat transfers.
  - in_ready is low in that cycle and high in the next.
  - The third histogram is accepted only then.
- Reset mid-stream: assert rst after beat 4 of a histogram.
  - out_valid falls immediately.
  - After release, a new histogram starts at bin_index 0 with its own values.
